// File: rtl/sine_nco_pkg.sv
// sine_nco_pkg: shared widths, FSM state type and phase-field helpers for the sine NCO.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package sine_nco_pkg;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 8;
  localparam int FRAC_W  = 8;
  localparam int DATA_W  = 21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    INTERP = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // ROM index: the top ADDR_W bits of the phase word.
  function automatic logic [ADDR_W-1:0] phase_idx(input logic [PHASE_W-1:0] phase);
    return phase[PHASE_W-1 -: ADDR_W];
  endfunction

  // Interpolation fraction: the FRAC_W bits directly below the index.
  function automatic logic [FRAC_W-1:0] phase_frac(input logic [PHASE_W-1:0] phase);
    return phase[PHASE_W-ADDR_W-1 -: FRAC_W];
  endfunction

endpackage

// File: rtl/sine_nco_interp.sv
// sine_nco_interp: linear interpolation y = a + floor((b - a) * frac / 2^FRAC_W).
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module sine_nco_interp
  import sine_nco_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FRAC_W-1:0] frac,
  output logic [DATA_W-1:0] y
);

  // One extra bit keeps b - a exact across the full signed range.
  logic signed [DATA_W:0]        d;
  logic signed [DATA_W+FRAC_W:0] d_x;
  logic signed [DATA_W+FRAC_W:0] f_x;
  logic signed [DATA_W+FRAC_W:0] p;

  assign d   = $signed({b[DATA_W-1], b}) - $signed({a[DATA_W-1], a});
  assign d_x = {{FRAC_W{d[DATA_W]}}, d};
  assign f_x = $signed({{(DATA_W+1){1'b0}}, frac});
  assign p   = d_x * f_x;

  // Taking bits above FRAC_W is an arithmetic shift (floor); the sum stays
  // between a and b so truncation to DATA_W never wraps.
  assign y = a + p[DATA_W+FRAC_W-1:FRAC_W];

endmodule

// File: rtl/sine_nco.sv
// sine_nco: phase-accumulator NCO feeding a registered dual-port sine ROM; define SINE_NCO_INTERP_EN for linear interpolation, else nearest-lower lookup.
// Latency: sample_valid rises on the third edge counting the tick-accept edge (accept -> FETCH -> INTERP -> HOLD).
// Backpressure: sample held until sample_ready; ticks that cannot start a sample still advance phase and set sticky overrun.
module sine_nco
  import sine_nco_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_we,
  input  logic               phase_clr,
  input  logic               sample_tick,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               lut_ena,
  output logic [ADDR_W-1:0]  lut_addra,
  input  logic [DATA_W-1:0]  lut_douta,
  output logic               lut_enb,
  output logic [ADDR_W-1:0]  lut_addrb,
  input  logic [DATA_W-1:0]  lut_doutb
);

  state_t             state;
  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] fcw_reg;
  logic [PHASE_W-1:0] snap;
  logic               tick_acc;
  logic [DATA_W-1:0]  interp_y;

  // A tick starts a sample only when idle or when the held sample leaves on this edge.
  assign tick_acc = sample_tick && ((state == IDLE) || ((state == HOLD) && sample_ready));
  // Phase used for the sample being started; phase_clr makes it zero.
  assign snap     = phase_clr ? '0 : phase_acc;

`ifdef SINE_NCO_INTERP_EN
  logic [FRAC_W-1:0] frac_q;

  sine_nco_interp u_interp (
    .a    (lut_douta),
    .b    (lut_doutb),
    .frac (frac_q),
    .y    (interp_y)
  );
`else
  assign interp_y  = lut_douta;
  assign lut_enb   = 1'b0;
  assign lut_addrb = '0;
`endif

  // Phase accumulator advances on every tick, accepted or not, so frequency is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      fcw_reg   <= '0;
    end else begin
      if (fcw_we)
        fcw_reg <= fcw;
      if (phase_clr)
        phase_acc <= tick_acc ? fcw_reg : '0;
      else if (sample_tick)
        phase_acc <= phase_acc + fcw_reg;
    end
  end

  // Sample FSM: ROM enables pulse for the FETCH cycle only; sample registered in INTERP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sample       <= '0;
      sample_valid <= 1'b0;
      lut_ena      <= 1'b0;
      lut_addra    <= '0;
`ifdef SINE_NCO_INTERP_EN
      lut_enb      <= 1'b0;
      lut_addrb    <= '0;
      frac_q       <= '0;
`endif
    end else begin
      lut_ena <= tick_acc;
      if (tick_acc)
        lut_addra <= phase_idx(snap);
`ifdef SINE_NCO_INTERP_EN
      lut_enb <= tick_acc;
      if (tick_acc) begin
        lut_addrb <= phase_idx(snap) + ADDR_W'(1);
        frac_q    <= phase_frac(snap);
      end
`endif
      case (state)
        IDLE: begin
          if (tick_acc)
            state <= FETCH;
        end
        FETCH: begin
          state <= INTERP;
        end
        INTERP: begin
          sample       <= interp_y;
          sample_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            state        <= tick_acc ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun: a lost tick wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (sample_tick && !tick_acc)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sine_nco.sv
// tb_sine_nco: scoreboard bench for sine_nco with a registered-read ROM model.
// Latency: model expects lut_ena after the accept edge and sample_valid two edges later.
// Backpressure: sample_ready driven directly and randomly.
module tb_sine_nco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fcw;
  logic        fcw_we, phase_clr, sample_tick, sample_ready, overrun_clr;
  logic [20:0] sample;
  logic        sample_valid, overrun;
  logic        lut_ena, lut_enb;
  logic [7:0]  lut_addra, lut_addrb;
  logic [20:0] lut_douta, lut_doutb;

  always #5 clk = ~clk;

  sine_nco dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fcw          (fcw),
    .fcw_we       (fcw_we),
    .phase_clr    (phase_clr),
    .sample_tick  (sample_tick),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .lut_ena      (lut_ena),
    .lut_addra    (lut_addra),
    .lut_douta    (lut_douta),
    .lut_enb      (lut_enb),
    .lut_addrb    (lut_addrb),
    .lut_doutb    (lut_doutb)
  );

  // ROM with one-cycle registered reads
  logic signed [20:0] rom [256];
  always @(posedge clk) begin
    if (lut_ena) lut_douta <= rom[lut_addra];
    if (lut_enb) lut_doutb <= rom[lut_addrb];
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sample for a phase word, straight from the interpolation rule
  function automatic logic [20:0] exp_sample(input logic [31:0] ph);
    int idx, fr, a, b, p, q;
    idx = int'(ph[31:24]);
    fr  = int'(ph[23:16]);
    a   = int'($signed(rom[idx]));
    b   = int'($signed(rom[(idx + 1) % 256]));
`ifdef SINE_NCO_INTERP_EN
    p = (b - a) * fr;
    q = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    return 21'(a + q);
`else
    p = b;
    q = fr;
    return 21'(a + 0 * (p + q));
`endif
  endfunction

  typedef struct { logic [7:0]  a; int e; } fetch_t;
  typedef struct { logic [20:0] s; int e; } samp_t;

  fetch_t      fq[$];
  samp_t       sq[$];
  int          edge_cnt;
  int          acc_edge;
  bit          busy;
  bit          m_ov;
  logic [31:0] m_phase;
  logic [31:0] m_fcw;

  // Behavioural model: one sample in flight, released by ready once it has been visible
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt = 0;
      acc_edge = 0;
      busy     = 0;
      m_ov     = 0;
      m_phase  = 0;
      m_fcw    = 0;
      fq.delete();
      sq.delete();
    end else begin
      bit          held, acc;
      logic [31:0] base;
      fetch_t      f;
      samp_t       s;
      edge_cnt++;
      held = busy && (edge_cnt >= acc_edge + 3);
      acc  = sample_tick && (!busy || (held && sample_ready));
      if (held && sample_ready) busy = 0;
      if (acc) begin
        base = phase_clr ? 32'd0 : m_phase;
        f.a = base[31:24]; f.e = edge_cnt; fq.push_back(f);
        s.s = exp_sample(base); s.e = edge_cnt; sq.push_back(s);
        busy     = 1;
        acc_edge = edge_cnt;
        m_phase  = base + m_fcw;
      end else if (phase_clr) begin
        m_phase = 0;
      end else if (sample_tick) begin
        m_phase = m_phase + m_fcw;
      end
      if (sample_tick && !acc) m_ov = 1;
      else if (overrun_clr)    m_ov = 0;
      if (fcw_we) m_fcw = fcw;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard between edges
  bit          prev_v;
  logic [20:0] cur_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      bit          exp_v;
      fetch_t      f;
      samp_t       s;
      logic [7:0]  nb;
      exp_v = busy && (edge_cnt >= acc_edge + 2);
      chk("overrun", overrun, m_ov);
      chk("sample_valid", sample_valid, exp_v);
      if (lut_ena) begin
        if (fq.size() == 0) chk("spurious lut_ena", 1, 0);
        else begin
          f  = fq.pop_front();
          nb = f.a + 8'd1;
          chk("fetch edge", edge_cnt, f.e);
          chk("lut_addra", lut_addra, f.a);
`ifdef SINE_NCO_INTERP_EN
          chk("lut_enb", lut_enb, 1);
          chk("lut_addrb", lut_addrb, nb);
`else
          chk("lut_enb", lut_enb, 0);
          chk("lut_addrb", lut_addrb, nb & 8'd0);
`endif
        end
      end else begin
        chk("lut_enb idle", lut_enb, 0);
      end
      if (fq.size() > 0 && edge_cnt > fq[0].e) begin
        chk("fetch missing", 0, 1);
        void'(fq.pop_front());
      end
      if (sample_valid && !prev_v) begin
        if (sq.size() == 0) chk("spurious sample", 1, 0);
        else begin
          s = sq.pop_front();
          cur_exp = s.s;
          chk("sample", sample, s.s);
          chk("valid edge", edge_cnt, s.e + 2);
        end
      end else if (sample_valid) begin
        chk("sample hold", sample, cur_exp);
      end
      if (sq.size() > 0 && edge_cnt > sq[0].e + 2) begin
        chk("sample missing", 0, 1);
        void'(sq.pop_front());
      end
      prev_v = sample_valid;
    end
  end

  task automatic cyc(input bit t, input bit we = 1'b0, input bit c = 1'b0, input bit oc = 1'b0);
    @(negedge clk);
    sample_tick = t;
    fcw_we      = we;
    phase_clr   = c;
    overrun_clr = oc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sample"},       sample,       0);
    chk({tag, " sample_valid"}, sample_valid, 0);
    chk({tag, " overrun"},      overrun,      0);
    chk({tag, " lut_ena"},      lut_ena,      0);
    chk({tag, " lut_enb"},      lut_enb,      0);
    chk({tag, " lut_addra"},    lut_addra,    0);
    chk({tag, " lut_addrb"},    lut_addrb,    0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 0; fcw = 0; fcw_we = 0; phase_clr = 0;
    sample_tick = 0; sample_ready = 1; overrun_clr = 0;
    for (int i = 0; i < 256; i++) rom[i] = 21'($urandom);
    rom[0]     = 21'h000000;
    rom[1]     = 21'h000100;
    rom[8'h7F] = 21'h000400;
    rom[8'h80] = 21'h1FFC00;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;

    // integer stepping
    fcw = 32'h0100_0000; cyc(0, 1);
    repeat (4) begin cyc(1); repeat (7) cyc(0); end

    // fractional phase
    fcw = 32'h0080_0000; cyc(0, 1, 1);
    repeat (3) begin cyc(1); repeat (5) cyc(0); end

    // sign crossing at 0x7F80_0000
    fcw = 32'h7F80_0000; cyc(0, 1);
    cyc(1, 0, 1); repeat (5) cyc(0);
    cyc(1);       repeat (5) cyc(0);

    // index wrap at 0xFF80_0000
    fcw = 32'hFF80_0000; cyc(0, 1);
    cyc(1, 0, 1); repeat (5) cyc(0);
    cyc(1);       repeat (5) cyc(0);

    // backpressure and overrun
    fcw = 32'h0100_0000; cyc(0, 1);
    sample_ready = 0;
    cyc(1); repeat (4) cyc(0);
    cyc(1); repeat (4) cyc(0);
    sample_ready = 1;
    cyc(1); repeat (5) cyc(0);
    cyc(0, 0, 0, 1); cyc(0);

    // back-to-back handshake plus tick
    repeat (6) begin cyc(1); cyc(0); cyc(0); end
    repeat (4) cyc(0);

    // asynchronous reset while in FETCH
    cyc(1); cyc(0);
    fcw = 32'h0300_0000; fcw_we = 1; phase_clr = 1;
    #1 rst_n = 0;
    #1 chk_reset("mid-fetch reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; sample_tick = 1; fcw_we = 1; phase_clr = 1;
    repeat (5) cyc(0);
    cyc(1); repeat (5) cyc(0);
    cyc(1); repeat (5) cyc(0);

    // randomized traffic
    repeat (3000) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) fcw = $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0);
    end
    sample_ready = 1;
    repeat (10) cyc(0);
    chk("sample queue drained", sq.size(), 0);
    chk("fetch queue drained",  fq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
